cphy_trio_clock_recovery: RTL and testbench

- Synchronous clock and data recovery for one C-PHY trio, sampled by a local oversampling clock.
- Synchronises the three wire levels and detects a symbol transition on any wire.
- Merges inter-wire skew into a single symbol event, captures the settled 3-bit wire state, and emits a one-cycle symbol strobe plus a recovered toggle clock.
- Sits between the trio receiver comparators and the symbol decoder; replaces the delay-line edge/pulse clock generator with a parametrised, fully synchronous design.

---
 rtl/cphy_trio_clock_recovery.sv | 165 ++++++++++++++++
 tb/tb_cphy_trio_clock_recovery.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cphy_trio_clock_recovery.sv
// Fully synchronous clock/data recovery for one C-PHY trio on an oversampling clock.
// Optional illegal-state checking is built only when CPHY_INVALID_CHECK_EN is defined.
module cphy_trio_clock_recovery #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned HOLDOFF_CYCLES = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        En,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    output logic        SymValid,
    output logic [2:0]  SymState,
    output logic        OutClk,
    output logic        IdleFlag,
    output logic [15:0] SymCount,
    output logic        InvalidState,
    output logic [7:0]  ErrCount
);

    localparam int unsigned MaxA   = (SYNC_STAGES > SETTLE_CYCLES) ? SYNC_STAGES : SETTLE_CYCLES;
    localparam int unsigned MaxCnt = (MaxA > HOLDOFF_CYCLES) ? MaxA : HOLDOFF_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StInit, StIdle, StSettle, StHoldoff} state_e;

    state_e            stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [2:0]        refQ, refD;
    logic [IdleW-1:0]  idleCntQ;
    logic [SYNC_STAGES-1:0] syncA, syncB, syncC;
    logic [2:0]        syncState;
    logic              capture;
    logic              newSym;

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            syncA <= '0;
            syncB <= '0;
            syncC <= '0;
        end else begin
            syncA <= {syncA[SYNC_STAGES-2:0], A};
            syncB <= {syncB[SYNC_STAGES-2:0], B};
            syncC <= {syncC[SYNC_STAGES-2:0], C};
        end
    end

    assign syncState = {syncA[SYNC_STAGES-1], syncB[SYNC_STAGES-1], syncC[SYNC_STAGES-1]};

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            stateQ <= StInit;
            cntQ   <= CntW'(SYNC_STAGES);
            refQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            refQ   <= refD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        refD    = refQ;
        capture = 1'b0;
        if (!En) begin
            stateD = StIdle;
            cntD   = '0;
            refD   = syncState;
        end else begin
            unique case (stateQ)
                StInit: begin
                    if (cntQ == '0) begin
                        refD   = syncState;
                        stateD = StIdle;
                    end else begin
                        cntD = cntQ - CntW'(1);
                    end
                end
                StIdle: begin
                    if (syncState != refQ) begin
                        stateD = StSettle;
                        cntD   = CntW'(SETTLE_CYCLES - 1);
                    end
                end
                StSettle: begin
                    // Later wire edges are absorbed here; the skewed symbol is sampled once.
                    if (cntQ == '0) begin
                        capture = 1'b1;
                        refD    = syncState;
                        if (HOLDOFF_CYCLES == 0) begin
                            stateD = StIdle;
                        end else begin
                            stateD = StHoldoff;
                            cntD   = CntW'(HOLDOFF_CYCLES - 1);
                        end
                    end else begin
                        cntD = cntQ - CntW'(1);
                    end
                end
                StHoldoff: begin
                    if (cntQ == '0) begin
                        stateD = StIdle;
                    end else begin
                        cntD = cntQ - CntW'(1);
                    end
                end
                default: stateD = StInit;
            endcase
        end
    end

    // A glitch that has already returned to the reference level is not a symbol.
    assign newSym = capture && (syncState != refQ);

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            SymValid <= 1'b0;
            SymState <= '0;
            OutClk   <= 1'b0;
            SymCount <= '0;
            idleCntQ <= '0;
        end else begin
            SymValid <= newSym;
            if (newSym) begin
                SymState <= syncState;
                OutClk   <= ~OutClk;
                SymCount <= SymCount + 16'd1;
            end
            if (!En || newSym) begin
                idleCntQ <= '0;
            end else if (stateQ == StIdle && idleCntQ < IdleW'(TIMEOUT_CYCLES)) begin
                idleCntQ <= idleCntQ + IdleW'(1);
            end
        end
    end

    assign IdleFlag = (idleCntQ >= IdleW'(TIMEOUT_CYCLES));

`ifdef CPHY_INVALID_CHECK_EN
    logic illegal;
    assign illegal = (syncState == 3'b000) || (syncState == 3'b111);

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            InvalidState <= 1'b0;
            ErrCount     <= '0;
        end else begin
            InvalidState <= newSym && illegal;
            if (newSym && illegal && ErrCount != 8'hFF) begin
                ErrCount <= ErrCount + 8'd1;
            end
        end
    end
`else
    assign InvalidState = 1'b0;
    assign ErrCount     = 8'h00;
`endif

endmodule

// File: tb/tb_cphy_trio_clock_recovery.sv
// Randomised self-checking bench for cphy_trio_clock_recovery against a symbol-level model.
module tb_cphy_trio_clock_recovery;

    logic        Clk = 1'b0;
    logic        RstN, En, A, B, C;
    logic        SymValid, OutClk, IdleFlag, InvalidState;
    logic [2:0]  SymState;
    logic [15:0] SymCount;
    logic [7:0]  ErrCount;

`ifdef CPHY_INVALID_CHECK_EN
    localparam bit InvChk = 1'b1;
`else
    localparam bit InvChk = 1'b0;
`endif
    localparam int Latency = 5;

    cphy_trio_clock_recovery dut (
        .Clk(Clk), .RstN(RstN), .En(En), .A(A), .B(B), .C(C),
        .SymValid(SymValid), .SymState(SymState), .OutClk(OutClk), .IdleFlag(IdleFlag),
        .SymCount(SymCount), .InvalidState(InvalidState), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nErrors = 0;

    // Symbol-level model state
    logic [2:0]  lastState;
    logic [2:0]  expSymState;
    logic [15:0] expCount;
    logic        expOutClk;
    int          expErr;

    // Observations from the last window
    int obsPulses, obsFirst, obsSecond, invHit, invStray;
    logic [2:0] obsSt;
    logic idleAt4, idleAt5;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic setWires(input logic [2:0] s);
        {A, B, C} = s;
    endtask

    task automatic resetModel(input logic [2:0] wires);
        lastState   = wires;
        expSymState = 3'b000;
        expCount    = '0;
        expOutClk   = 1'b0;
        expErr      = 0;
    endtask

    task automatic modelSym(input logic [2:0] s);
        if (s != lastState) begin
            expCount    = expCount + 16'd1;
            expOutClk   = ~expOutClk;
            expSymState = s;
            if (InvChk && (s == 3'b000 || s == 3'b111) && expErr < 255) expErr++;
            lastState = s;
        end
    endtask

    // Drive s1 now (just after edge N), and s2 just after edge N+k2 when k2 > 0.
    task automatic drive2(input logic [2:0] s1, input int k2, input logic [2:0] s2, input int len);
        obsPulses = 0; obsFirst = -1; obsSecond = -1; obsSt = '0;
        invHit = 0; invStray = 0; idleAt4 = 1'b0; idleAt5 = 1'b0;
        setWires(s1);
        for (int k = 1; k <= len; k++) begin
            tick;
            if (SymValid) begin
                obsPulses++;
                if (obsPulses == 1) begin
                    obsFirst = k;
                    obsSt    = SymState;
                end else if (obsPulses == 2) begin
                    obsSecond = k;
                end
            end
            if (InvalidState && SymValid) invHit++;
            else if (InvalidState) invStray++;
            if (k == 4) idleAt4 = IdleFlag;
            if (k == 5) idleAt5 = IdleFlag;
            if (k == k2) setWires(s2);
        end
    endtask

    task automatic checkOutputs(input string tag);
        checkEq({tag, "/SymState"}, 32'(SymState), 32'(expSymState));
        checkEq({tag, "/OutClk"}, 32'(OutClk), 32'(expOutClk));
        checkEq({tag, "/SymCount"}, 32'(SymCount), 32'(expCount));
        checkEq({tag, "/ErrCount"}, 32'(ErrCount), 32'(expErr));
        checkEq({tag, "/invStray"}, 32'(invStray), 32'd0);
    endtask

    // startK: window cycle after which the wires first differ from the last symbol.
    task automatic expectOne(input string tag, input logic [2:0] fin, input int startK);
        bit willSym;
        bit illegal;
        willSym = (fin != lastState);
        illegal = (fin == 3'b000) || (fin == 3'b111);
        modelSym(fin);
        checkEq({tag, "/pulses"}, 32'(obsPulses), 32'(willSym));
        if (willSym) begin
            checkEq({tag, "/latency"}, 32'(obsFirst), 32'(startK + Latency));
            checkEq({tag, "/stateAtStrobe"}, 32'(obsSt), 32'(fin));
        end
        checkEq({tag, "/invHit"}, 32'(invHit), 32'(willSym && InvChk && illegal));
        checkOutputs(tag);
    endtask

    initial begin
        logic [2:0] s1, s2, fin;
        int k2, startK, enPulses;

        // Reset held with wires at 100
        RstN = 1'b0; En = 1'b1;
        setWires(3'b100);
        resetModel(3'b100);
        repeat (3) tick;
        checkEq("reset/SymValid", 32'(SymValid), 32'd0);
        checkEq("reset/IdleFlag", 32'(IdleFlag), 32'd0);
        checkEq("reset/InvalidState", 32'(InvalidState), 32'd0);
        invStray = 0;
        checkOutputs("reset");

        // INIT must adopt 100 as reference without strobing
        RstN = 1'b1;
        drive2(3'b100, 0, 3'b100, 12);
        expectOne("init", 3'b100, 0);

        drive2(3'b010, 0, 3'b010, 12);
        expectOne("single", 3'b010, 0);

        drive2(3'b111, 0, 3'b111, 12);
        expectOne("to111", 3'b111, 0);

        // A after N, B after N+1: one merged symbol
        drive2(3'b011, 1, 3'b001, 12);
        expectOne("skew", 3'b001, 0);

        // Second change lands during holdoff and is picked up afterwards
        drive2(3'b100, 6, 3'b110, 16);
        checkEq("holdoff/pulses", 32'(obsPulses), 32'd2);
        checkEq("holdoff/first", 32'(obsFirst), 32'(Latency));
        checkEq("holdoff/firstState", 32'(obsSt), 32'(3'b100));
        checkEq("holdoff/second", 32'(obsSecond), 32'd11);
        modelSym(3'b100);
        modelSym(3'b110);
        checkOutputs("holdoff");

        // Glitch visible to the synchroniser for one cycle, then returned
        drive2(3'b100, 1, 3'b110, 12);
        expectOne("glitchSampled", 3'b110, 0);
        // Sub-cycle glitch between edges
        setWires(3'b010);
        #2;
        drive2(3'b110, 0, 3'b110, 12);
        expectOne("glitchShort", 3'b110, 0);

        // Idle timeout
        repeat (40) tick;
        checkEq("idle/early", 32'(IdleFlag), 32'd0);
        repeat (40) tick;
        checkEq("idle/timeout", 32'(IdleFlag), 32'd1);
        drive2(3'b011, 0, 3'b011, 12);
        checkEq("idle/beforeStrobe", 32'(idleAt4), 32'd1);
        checkEq("idle/atStrobe", 32'(idleAt5), 32'd0);
        expectOne("idleSym", 3'b011, 0);

        // Disabled: wire activity is tracked silently
        En = 1'b0;
        enPulses = 0;
        for (int i = 0; i < 3; i++) begin
            setWires(3'(i + 4));
            repeat (3) begin
                tick;
                if (SymValid) enPulses++;
            end
        end
        repeat (5) begin
            tick;
            if (SymValid) enPulses++;
        end
        checkEq("enable/offIdle", 32'(IdleFlag), 32'd0);
        En = 1'b1;
        drive2(3'b110, 0, 3'b110, 12);
        checkEq("enable/offPulses", 32'(enPulses), 32'd0);
        lastState = 3'b110;
        expectOne("enable/reEnable", 3'b110, 0);

        // Reset mid-symbol discards it and reinitialises on the new wire state
        setWires(3'b001);
        repeat (3) tick;
        RstN = 1'b0;
        tick;
        resetModel(3'b001);
        checkEq("midReset/SymValid", 32'(SymValid), 32'd0);
        invStray = 0;
        checkOutputs("midReset");
        RstN = 1'b1;
        drive2(3'b001, 0, 3'b001, 12);
        expectOne("midReset/init", 3'b001, 0);

        // Randomised symbols with optional one-cycle skew
        for (int i = 0; i < 40; i++) begin
            s1 = 3'($urandom_range(7, 0));
            s2 = 3'($urandom_range(7, 0));
            k2 = $urandom_range(1, 0);
            fin = (k2 == 1) ? s2 : s1;
            startK = (s1 != lastState) ? 0 : k2;
            drive2(s1, k2, s2, 12);
            expectOne("rand", fin, startK);
        end

        // Long run of illegal states exercises ErrCount saturation
        for (int i = 0; i < 300; i++) begin
            fin = (lastState == 3'b111) ? 3'b000 : 3'b111;
            drive2(fin, 0, fin, 8);
            expectOne("invalid", fin, 0);
        end
        checkEq("invalid/final", 32'(ErrCount), InvChk ? 32'hFF : 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
